// File: rtl/mux_imm_seq_pkg.sv
// mux_imm_seq_pkg: shared source-select codes and prefix FSM state encoding
// for the registered immediate-source mux (mux_imm_seq) and its prefix FSM.
package mux_imm_seq_pkg;

   // Operand source indices; IMM is the only prefix-eligible source
   localparam int unsigned IMM_SRC_IMM   = 0;
   localparam int unsigned IMM_SRC_SHAMT = 1;
   localparam int unsigned IMM_SRC_DBL   = 2;

   // Prefix assembly state: no prefix held, or an upper half waiting
   typedef enum logic {
      IMS_IDLE     = 1'b0,
      IMS_HAVE_PFX = 1'b1
   } ims_state_t;

endpackage

// File: rtl/mux_imm_seq_prefix_fsm.sv
// imm_prefix_fsm: holds the upper half supplied by a PREFIX beat until the
// next operand beat. A following IMM-source beat merges with it; any other
// operand beat discards it. A newer prefix overwrites an older one.
module imm_prefix_fsm
   import mux_imm_seq_pkg::*;
#(
   parameter int HALF = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            acc,
   input  logic            prefix,
   input  logic            sel_imm,
   input  logic [HALF-1:0] prefix_data,
   output logic            merge_en,
   output logic [HALF-1:0] pfx_val,
   output logic            prefix_pend
);

   ims_state_t      state_p1;
   logic [HALF-1:0] pfx_p1;
   logic            pend_p1;

   // State, stored upper half and pending flag advance only on accepted beats
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_p1 <= IMS_IDLE;
         pfx_p1   <= '0;
         pend_p1  <= 1'b0;
      end else if (acc) begin
         if (prefix) begin
            state_p1 <= IMS_HAVE_PFX;
            pfx_p1   <= prefix_data;
            pend_p1  <= 1'b1;
         end else begin
            // every operand beat consumes or discards the held prefix
            state_p1 <= IMS_IDLE;
            pend_p1  <= 1'b0;
         end
      end
   end

   assign merge_en    = (state_p1 == IMS_HAVE_PFX) && sel_imm;
   assign pfx_val     = pfx_p1;
   assign prefix_pend = pend_p1;

endmodule

// File: rtl/mux_imm_seq.sv
// mux_imm_seq: registered NSRC-way operand mux with valid/ready handshake and
// prefix-immediate assembly ({prefix, SRC0 low half}) on the IMM source.
// Optional build macro IMM_PREFIX_SEXT_EN: an IMM beat with no prefix pending
// sign-extends SRC0's low half instead of passing SRC0 through unchanged.
module mux_imm_seq
   import mux_imm_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NSRC  = 3,
   parameter int SEL_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NSRC*WIDTH-1:0] src,
   input  logic [SEL_W-1:0]      ctl,
   input  logic                  prefix,
   input  logic [WIDTH/2-1:0]    prefix_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  prefix_pend
);

   localparam int HALF = WIDTH / 2;

`ifdef IMM_PREFIX_SEXT_EN
   function automatic logic signed [WIDTH-1:0] sext_half(input logic signed [HALF-1:0] v);
      logic signed [WIDTH-1:0] r;
      r = v;
      return r;
   endfunction
`endif

   logic             acc_p0;
   logic             sel_imm_p0;
   logic             merge_en_p0;
   logic [HALF-1:0]  pfx_val_p0;
   logic [WIDTH-1:0] nxt_p0;
   logic [WIDTH-1:0] out_p1;
   logic             vld_p1;

   assign in_ready   = !vld_p1 || out_ready;
   assign acc_p0     = in_valid && in_ready;
   assign sel_imm_p0 = (ctl == SEL_W'(IMM_SRC_IMM));

   imm_prefix_fsm #(
      .HALF (HALF)
   ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .acc         (acc_p0),
      .prefix      (prefix),
      .sel_imm     (sel_imm_p0),
      .prefix_data (prefix_data),
      .merge_en    (merge_en_p0),
      .pfx_val     (pfx_val_p0),
      .prefix_pend (prefix_pend)
   );

   // Source select: IMM merges or passes, 1..NSRC-1 pass, out-of-range gives 0
   always_comb begin
      nxt_p0 = '0;
      if (sel_imm_p0) begin
         if (merge_en_p0) begin
            nxt_p0 = {pfx_val_p0, src[HALF-1:0]};
         end else begin
`ifdef IMM_PREFIX_SEXT_EN
            nxt_p0 = sext_half($signed(src[HALF-1:0]));
`else
            nxt_p0 = src[WIDTH-1:0];
`endif
         end
      end else begin
         for (int k = 1; k < NSRC; k++) begin
            if (ctl == SEL_W'(k)) nxt_p0 = src[k*WIDTH +: WIDTH];
         end
      end
   end

   // ---- stage p0 -> p1: output register and valid ----
   // Load on operand accept; otherwise drop valid once the consumer takes OUT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_p1 <= '0;
         vld_p1 <= 1'b0;
      end else if (acc_p0 && !prefix) begin
         out_p1 <= nxt_p0;
         vld_p1 <= 1'b1;
      end else if (vld_p1 && out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out       = out_p1;
   assign out_valid = vld_p1;

endmodule
